// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared arbiter state encoding and transfer size codes
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

endpackage

// File: rtl/arb_prio_pick.sv
// rtl/arb_prio_pick.sv - combinational lowest-index picker over unmasked valid bits
module arb_prio_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] valid,
    input  logic [N-1:0] mask,
    output logic [N-1:0] grant
);

    logic [N-1:0] eligible;
    logic         found;

    // A set mask bit removes that requester from this round only.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        eligible = valid & ~mask;
        for (int i = 0; i < N; i++) begin
            if (eligible[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_mem_arbiter.sv
// rtl/spi_mem_arbiter.sv - priority arbiter with requester-0 streak limit in front of a SPI memory controller
module spi_mem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    input  logic [NUM_REQ*2-1:0]  req_size,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [31:0]           m_addr,
    output logic [31:0]           m_wdata,
    output logic                  m_we,
    output logic [1:0]            m_size,
    input  logic                  m_done,
    input  logic [31:0]           m_rdata,
    output logic                  busy
);

    localparam int               SW         = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [SW-1:0]    STREAK_ONE = SW'(1);
    localparam logic [NUM_REQ-1:0] REQ0     = NUM_REQ'(1);

    arb_state_t          state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic [NUM_REQ-1:0]  owner_q, owner_d;
    logic [31:0]         m_addr_q, m_addr_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic                m_we_q, m_we_d;
    logic [1:0]          m_size_q, m_size_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;

    logic                others_valid;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [31:0]         sel_addr, sel_wdata;
    logic                sel_we;
    logic [1:0]          sel_size;
    logic                complete;

    // Requester 0 sits out one round once its streak is spent and someone else waits.
    assign others_valid = |(req_valid & ~REQ0);
    assign pick_mask    = (streak_q == STREAK_MAX && others_valid) ? REQ0 : '0;

    arb_prio_pick #(.N(NUM_REQ)) u_pick (
        .valid (req_valid),
        .mask  (pick_mask),
        .grant (pick_grant)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        sel_size  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr  = req_addr[i*32 +: 32];
                sel_wdata = req_wdata[i*32 +: 32];
                sel_we    = req_we[i];
                sel_size  = req_size[i*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_we_d      = m_we_q;
        m_size_d    = m_size_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = '0;
        m_valid     = 1'b0;
        complete    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid && !rst) begin
                    req_ready = pick_grant;
                    owner_d   = pick_grant;
                    m_addr_d  = sel_addr;
                    m_wdata_d = sel_wdata;
                    m_we_d    = sel_we;
                    m_size_d  = sel_size;
                    state_d   = ST_ISSUE;
                    if (pick_grant[0] && others_valid) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_ONE;
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (m_done) begin
                        complete = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (m_done) begin
                    complete = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            state_d     = ST_IDLE;
            rsp_valid_d = owner_q;
            rsp_rdata_d = m_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            owner_q     <= '0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_we_q      <= 1'b0;
            m_size_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_we_q      <= m_we_d;
            m_size_q    <= m_size_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_we      = m_we_q;
    assign m_size    = m_size_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/spi_mem_arbiter.md
SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the requester count (index 0 = data, 1 = instruction fetch, 2 = auxiliary/DMA).
REQ-002 The block SHALL have parameter MAX_STREAK, default 4, giving the maximum consecutive grants to requester 0 while another requester is pending.
REQ-003 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester transaction request.
REQ-006 req_addr  input  NUM_REQ*32  packed byte addresses, slice i*32 +: 32.
REQ-007 req_we  input  NUM_REQ  per-requester write flag.
REQ-008 req_wdata  input  NUM_REQ*32  packed write data.
REQ-009 req_size  input  NUM_REQ*2  packed size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-010 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-011 rsp_valid  output  NUM_REQ  one-hot completion strobe.
REQ-012 rsp_rdata  output  32  read data, shared across requesters.
REQ-013 m_valid  output  1  request to the shared SPI memory controller.
REQ-014 m_ready  input  1  controller accepts the request.
REQ-015 m_addr, m_wdata (32 each), m_we (1), m_size (2)  output  latched request fields.
REQ-016 m_done  input  1  controller completion strobe.
REQ-017 m_rdata  input  32  controller read data, valid with m_done.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-020 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally, one-hot, to the winner; the winner's fields SHALL be latched, owner recorded, and the next state SHALL be ISSUE.
REQ-021 Winner selection SHALL be the lowest valid index, except that requester 0 is masked when streak == MAX_STREAK and another request is valid.
REQ-022 streak SHALL increment (saturating at MAX_STREAK) when requester 0 is granted while any other req_valid is high; it SHALL clear on any grant to another requester, or when requester 0 is granted alone.
REQ-023 In ISSUE, m_valid SHALL be 1 and m_* fields SHALL stay stable until m_ready; on m_ready the next state SHALL be WAIT.
REQ-024 If m_done arrives in the same cycle as m_ready, the transaction SHALL complete directly to IDLE.
REQ-025 On completion, rsp_valid[owner] SHALL be 1 for exactly one cycle, with rsp_rdata = m_rdata registered.
REQ-026 The state SHALL return to IDLE in that same cycle, giving 1-cycle turnaround.
REQ-027 m_done in IDLE SHALL be ignored.
REQ-028 A request dropped before acceptance SHALL NOT be granted.
REQ-029 req_valid in ISSUE or WAIT SHALL NOT be accepted; req_ready SHALL be 0 there.
REQ-030 Reserved size 3 SHALL be forwarded unchanged; decoding it is the controller's responsibility.
REQ-031 Minimum latency SHALL be: accept at cycle 0, m_valid at cycle 1, rsp_valid in the cycle after m_done is sampled.

Reset
REQ-032 On rst: state = IDLE, streak = 0, owner = 0, and m_valid, req_ready, rsp_valid, busy, m_* and rsp_rdata SHALL all be 0.
REQ-033 A reset mid-transaction SHALL abandon it without issuing rsp_valid; the controller is reset by the same rst.

Structure
REQ-034 The state enum and size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) SHALL live in shared package soc_bus_pkg.
REQ-035 The masked lowest-index picker SHALL be sub-module arb_prio_pick (input mask and valid, output one-hot grant); it SHALL be purely combinational.

Verification
REQ-036 The bench SHALL cover: single fetch, req_valid = 3'b010, addr 0x00000100 -> req_ready = 010 at cycle 0, m_valid at cycle 1 with m_addr = 0x100, rsp_valid = 010 after m_done with m_rdata = 0xDEADBEEF returned.
REQ-037 The bench SHALL cover: simultaneous req_valid = 3'b111 -> grant order 0, 1, 2 across three transactions.
REQ-038 The bench SHALL cover starvation: requester 0 and requester 1 both held valid -> grants 0, 0, 0, 0, 1, 0, ... with streak = 4 on the fifth arbitration.
REQ-039 The bench SHALL cover: m_ready held low for 10 cycles -> m_* stable, req_ready = 0, busy = 1 throughout.
REQ-040 The bench SHALL cover: m_ready and m_done in the same cycle -> rsp_valid the next cycle and IDLE; a new grant is possible in that same cycle.
REQ-041 The bench SHALL cover: rst asserted while in WAIT -> all outputs 0 immediately (asynchronously); no rsp_valid; a fresh request after release is granted normally.
